// File: rtl/frame_sched_pkg.sv
// Shared types and control-block codes for the frame transmit scheduler.
// Codes match the 64-bit XGMII-style lane layout watched on the generator bus.
package frame_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_WAIT_SOF = 3'd2,
        ST_ACTIVE   = 3'd3,
        ST_IPG      = 3'd4
    } state_t;

    localparam logic [7:0] START_CODE     = 8'hFB;
    localparam logic [7:0] TERMINATE_CODE = 8'hFD;
    localparam logic [7:0] CTRL_SINGLE    = 8'h01;
    localparam logic [7:0] STOP_TX        = 8'h01;
    localparam logic [7:0] STOP_DATA      = 8'h02;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot winner searching upward from the slot after i_ptr.
// Purely combinational; the caller owns and advances the pointer.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt
);

    logic             found;
    logic [PTR_W-1:0] idx;
    int               sum;

    always_comb begin
        o_gnt = '0;
        found = 1'b0;
        idx   = '0;
        sum   = 0;
        // Offset 1..N_REQ wraps at most once, so a single subtraction is enough.
        for (int i = 1; i <= N_REQ; i++) begin
            sum = int'(i_ptr) + i;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end
            idx = PTR_W'(sum);
            if (!found && i_req[idx]) begin
                o_gnt[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_tx_scheduler.sv
// Frame scheduler: round-robin grant, one-cycle start, tracks FB/FD on the generator bus, then IPG.
// Registered outputs, start one cycle after request; optional watchdog under FRAME_SCHED_WATCHDOG_EN.
module frame_tx_scheduler
    import frame_sched_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int DATA_WIDTH     = 64,
    parameter int CTRL_WIDTH     = DATA_WIDTH / 8,
    parameter int IPG_CYCLES     = 3,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [8*N_REQ-1:0]    i_interrupt_req,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic [CTRL_WIDTH-1:0] i_tx_ctrl,
    output logic                  o_start,
    output logic [7:0]            o_interrupt,
    output logic [N_REQ-1:0]      o_grant,
    output logic [N_REQ-1:0]      o_done,
    output logic                  o_busy,
    output logic                  o_timeout
);

    localparam int PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int IPG_LAST = (IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0;
    localparam int IPG_W    = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [7:0]       intr_q, intr_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [IPG_W-1:0] ipg_cnt_q, ipg_cnt_d;

    logic [N_REQ-1:0] win;
    logic [PTR_W-1:0] win_idx;
    logic [7:0]       win_intr;
    logic             sof, eof;
    logic             wd_fire;
    logic             unused_tx_data;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .i_req (i_req),
        .i_ptr (ptr_q),
        .o_gnt (win)
    );

    always_comb begin
        win_idx  = '0;
        win_intr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) begin
                win_idx  = PTR_W'(i);
                win_intr = i_interrupt_req[8*i +: 8];
            end
        end
    end

    assign sof = (i_tx_ctrl == CTRL_WIDTH'(CTRL_SINGLE)) &&
                 (i_tx_data[DATA_WIDTH-1 -: 8] == START_CODE);
    assign eof = (i_tx_ctrl == CTRL_WIDTH'(CTRL_SINGLE)) &&
                 (i_tx_data[DATA_WIDTH-1 -: 8] == TERMINATE_CODE);
    assign unused_tx_data = ^i_tx_data[DATA_WIDTH-9:0];

`ifdef FRAME_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q;

    // Counter is zero on the first WAIT_SOF cycle; the edge that would take it to
    // TIMEOUT_CYCLES is the expiry edge. A terminate block on that edge wins.
    always_comb begin
        wd_cnt_d = '0;
        if (state_q == ST_WAIT_SOF || state_q == ST_ACTIVE) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
        wd_fire = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) &&
                  ((state_q == ST_WAIT_SOF) || (state_q == ST_ACTIVE && !eof));
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= wd_fire;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign wd_fire   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        intr_d    = intr_q;
        ptr_d     = ptr_q;
        ipg_cnt_d = ipg_cnt_q;
        start_d   = 1'b0;
        done_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (|i_req) begin
                    state_d = ST_START;
                    grant_d = win;
                    intr_d  = win_intr;
                    ptr_d   = win_idx;
                    start_d = 1'b1;
                end
            end
            ST_START: begin
                state_d = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                if (wd_fire) begin
                    state_d   = ST_IPG;
                    grant_d   = '0;
                    intr_d    = '0;
                    ipg_cnt_d = '0;
                end else if (sof) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (eof) begin
                    done_d    = grant_q;
                    state_d   = ST_IPG;
                    grant_d   = '0;
                    intr_d    = '0;
                    ipg_cnt_d = '0;
                end else if (wd_fire) begin
                    state_d   = ST_IPG;
                    grant_d   = '0;
                    intr_d    = '0;
                    ipg_cnt_d = '0;
                end
            end
            ST_IPG: begin
                if (ipg_cnt_q == IPG_W'(IPG_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    ipg_cnt_d = ipg_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                intr_d  = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            intr_q    <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            ptr_q     <= PTR_W'(N_REQ - 1);
            ipg_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            intr_q    <= intr_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            ptr_q     <= ptr_d;
            ipg_cnt_q <= ipg_cnt_d;
        end
    end

    assign o_start     = start_q;
    assign o_interrupt = intr_q;
    assign o_grant     = grant_q;
    assign o_done      = done_q;
    assign o_busy      = busy_q;

endmodule
